uart_line_assembler: RTL and testbench
======================================

// Module: uart_line_assembler
// PURPOSE
//  Sits between the UART controller's received-byte output and the LCD message
//  stage. Accumulates received ASCII bytes into a line buffer. On CR/LF it
//  commits the line as a space-padded message bus plus length for the display.
//  Double-buffered: the display bus only changes at a commit or clear.
// PARAMETERS
//  MAX_CHARS  61  line capacity in characters; legal range 1..511
// PORTS
//  iCLK         in   1              system clock (clk_25 domain)
//  iRST_N       in   1              async reset, active low
//  iRX_VALID    in   1              received byte available
//  iRX_DATA     in   8              received byte
//  oRX_READY    out  1              byte accepted on the edge where iRX_VALID & oRX_READY
//  iCLEAR       in   1              sync clear; highest priority
//  oMESS        out  MAX_CHARS*8    committed line; char i at [8*i+7:8*i]; unused chars = 8'h20
//  oLENGTH      out  9              committed char count, zero-extended
//  oLINE_DONE   out  1              1-cycle pulse when oMESS/oLENGTH update on commit
//  oOVERFLOW    out  1              sticky: a char was dropped because the buffer was full
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous, active-low (iRST_N); all regs on posedge iCLK.
//  Reset values: oMESS all 8'h20, oLENGTH 0, oLINE_DONE 0, oOVERFLOW 0, oRX_READY 1.
//    Internal state is COLLECT, count 0, work buffer all spaces, last_cr 0.
//  FSM:
//    COLLECT: oRX_READY=1.
//    COMMIT : oRX_READY=0, one cycle; always returns to COLLECT.
//  COLLECT accept rules (byte b):
//   - b==0x0D: last_cr<=1; go COMMIT.
//   - b==0x0A: if last_cr==1 && count==0, drop b and clear last_cr (CRLF counts as one
//       terminator). Otherwise go COMMIT.
//   - b in 0x20..0x7E: if count<MAX_CHARS, store at index count and increment count.
//       Otherwise drop b and set oOVERFLOW.
//   - any other byte: dropped.
//   - Every non-0x0D accepted byte clears last_cr.
//  COMMIT actions, on the edge leaving COMMIT:
//   - oMESS<=work buffer; oLENGTH<=count; oLINE_DONE<=1 for exactly one cycle.
//   - count<=0; work buffer<=all 8'h20.
//  Latency: terminator accepted on edge N; COMMIT state during cycle N..N+1;
//    oMESS/oLENGTH/oLINE_DONE change on edge N+1.
//  Empty line (terminator with count 0, not the LF of a CRLF pair): commits oLENGTH 0 and
//    all-space oMESS, with the pulse.
//  Full buffer: exactly MAX_CHARS chars commit normally. The (MAX_CHARS+1)th printable char
//    is dropped and oOVERFLOW is set; it stays set until iCLEAR or reset (not cleared by commit).
//  iCLEAR (sync): same edge, count<=0, work buffer and oMESS<=spaces, oLENGTH<=0,
//    oOVERFLOW<=0, last_cr<=0, state<=COLLECT, oLINE_DONE<=0.
//    Overrides a COMMIT in progress and any byte presented that cycle; the byte is not accepted.
//  Async reset mid-line: partial line is discarded and all outputs return to reset values.
//  iRX_DATA is ignored when iRX_VALID=0. The upstream stage holds the byte until accepted.
// CONFIGURATION
//  UART_LINE_BACKSPACE_EN defined:
//   - b==0x08 or b==0x7F in COLLECT: if count>0, count-- and the vacated slot<=8'h20.
//   - If count==0 the byte is ignored.
//   - Clears last_cr. Never affects oOVERFLOW.
//  Not defined: 0x08/0x7F fall under "any other byte" and are dropped; no extra logic.
// TESTING
//  1. Reset, send "HI",0x0D -> 2 edges after CR: oLENGTH=2, oMESS[15:0]=16'h4948,
//     all other chars 0x20, oLINE_DONE one cycle.
//  2. Send "AB",0x0D,0x0A,"C",0x0A -> exactly two oLINE_DONE pulses, with lengths 2 then 1.
//     The LF after the CR produces no empty line.
//  3. Send 62 x 'Z' then 0x0D (MAX_CHARS=61) -> oLENGTH=61, all chars 'Z', oOVERFLOW=1.
//     A following "Q",0x0D gives oLENGTH=1 with oOVERFLOW still 1.
//  4. Send "XY", assert iCLEAR on the cycle 0x0D is presented -> oRX_READY ignored,
//     oLENGTH=0, oMESS all spaces, no pulse. A later 0x0D commits oLENGTH=0.
//  5. Hold iRX_VALID continuously with "A",0x0D,"B" -> oRX_READY=0 for the COMMIT cycle only.
//     'B' is accepted one cycle later and appears in the next line, not lost.
//  6. UART_LINE_BACKSPACE_EN: "ABC",0x08,"D",0x0D -> oLENGTH=3, text "ABD".
//     0x08 at count 0 changes nothing. Without the macro: oLENGTH=4, text "ABCD".

Source files
------------

// File: rtl/uart_line_assembler.sv
// rtl/uart_line_assembler.sv - UART received-byte line assembler with double-buffered display output
//
// Collects printable ASCII bytes from the UART receive path into a work buffer
// and, on a CR or LF terminator, copies the line to a space-padded message bus
// together with its length. The display bus only changes on a commit or clear.
//
// Optional feature: define UART_LINE_BACKSPACE_EN to make 0x08/0x7F erase the
// last collected character. Without it those bytes are dropped.
//
// Ports:
//   iCLK        system clock
//   iRST_N      asynchronous reset, active low
//   iRX_VALID   received byte available
//   iRX_DATA    received byte
//   oRX_READY   byte accepted on an edge where iRX_VALID & oRX_READY
//   iCLEAR      synchronous clear, highest priority
//   oMESS       committed line, char i at [8*i+7:8*i], unused chars 8'h20
//   oLENGTH     committed character count
//   oLINE_DONE  one-cycle pulse when oMESS/oLENGTH update on commit
//   oOVERFLOW   sticky: a printable char was dropped because the buffer was full

module uart_line_assembler #(
    parameter int MAX_CHARS = 61
) (
    input  logic                   iCLK,
    input  logic                   iRST_N,
    input  logic                   iRX_VALID,
    input  logic [7:0]             iRX_DATA,
    output logic                   oRX_READY,
    input  logic                   iCLEAR,
    output logic [MAX_CHARS*8-1:0] oMESS,
    output logic [8:0]             oLENGTH,
    output logic                   oLINE_DONE,
    output logic                   oOVERFLOW
);

    localparam logic [8:0]             CAP    = 9'(MAX_CHARS);
    localparam logic [MAX_CHARS*8-1:0] SPACES = {MAX_CHARS{8'h20}};

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_COMMIT  = 1'b1
    } state_t;

    state_t                 state;
    logic [MAX_CHARS*8-1:0] work;
    logic [8:0]             count;
    logic                   last_cr;

    logic accept;
    logic is_cr;
    logic is_lf;
    logic is_print;

    assign accept   = iRX_VALID & oRX_READY;
    assign is_cr    = (iRX_DATA == 8'h0D);
    assign is_lf    = (iRX_DATA == 8'h0A);
    assign is_print = (iRX_DATA >= 8'h20) && (iRX_DATA <= 8'h7E);

`ifdef UART_LINE_BACKSPACE_EN
    logic is_bs;
    assign is_bs = (iRX_DATA == 8'h08) || (iRX_DATA == 8'h7F);
`endif

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= ST_COLLECT;
            work       <= SPACES;
            count      <= 9'd0;
            last_cr    <= 1'b0;
            oRX_READY  <= 1'b1;
            oMESS      <= SPACES;
            oLENGTH    <= 9'd0;
            oLINE_DONE <= 1'b0;
            oOVERFLOW  <= 1'b0;
        end else begin
            oLINE_DONE <= 1'b0;
            if (iCLEAR) begin
                // Clear wins over a pending commit and over any presented byte.
                state     <= ST_COLLECT;
                work      <= SPACES;
                count     <= 9'd0;
                last_cr   <= 1'b0;
                oRX_READY <= 1'b1;
                oMESS     <= SPACES;
                oLENGTH   <= 9'd0;
                oOVERFLOW <= 1'b0;
            end else begin
                case (state)
                    ST_COMMIT: begin
                        oMESS      <= work;
                        oLENGTH    <= count;
                        oLINE_DONE <= 1'b1;
                        work       <= SPACES;
                        count      <= 9'd0;
                        state      <= ST_COLLECT;
                        oRX_READY  <= 1'b1;
                    end
                    ST_COLLECT: begin
                        if (accept) begin
                            if (is_cr) begin
                                // last_cr survives the commit so a following LF
                                // at count 0 is folded into this terminator.
                                last_cr   <= 1'b1;
                                state     <= ST_COMMIT;
                                oRX_READY <= 1'b0;
                            end else begin
                                last_cr <= 1'b0;
                                if (is_lf) begin
                                    if (!(last_cr && (count == 9'd0))) begin
                                        state     <= ST_COMMIT;
                                        oRX_READY <= 1'b0;
                                    end
                                end else if (is_print) begin
                                    if (count < CAP) begin
                                        for (int i = 0; i < MAX_CHARS; i++) begin
                                            if (count == 9'(i)) begin
                                                work[8*i +: 8] <= iRX_DATA;
                                            end
                                        end
                                        count <= count + 9'd1;
                                    end else begin
                                        oOVERFLOW <= 1'b1;
                                    end
                                end
`ifdef UART_LINE_BACKSPACE_EN
                                else if (is_bs) begin
                                    if (count != 9'd0) begin
                                        for (int i = 0; i < MAX_CHARS; i++) begin
                                            if (count == 9'(i + 1)) begin
                                                work[8*i +: 8] <= 8'h20;
                                            end
                                        end
                                        count <= count - 9'd1;
                                    end
                                end
`endif
                            end
                        end
                    end
                    default: begin
                        state     <= ST_COLLECT;
                        oRX_READY <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_line_assembler.sv
// tb/tb_uart_line_assembler.sv - scoreboard bench for uart_line_assembler

`timescale 1ns/1ps

module tb_uart_line_assembler;

    localparam int MAX_CHARS = 61;
    localparam int W         = MAX_CHARS * 8;
    localparam logic [W-1:0] SPACES = {MAX_CHARS{8'h20}};

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         rx_valid = 1'b0;
    logic [7:0]   rx_data  = 8'h00;
    logic         clear    = 1'b0;
    logic         rx_ready;
    logic [W-1:0] mess;
    logic [8:0]   length;
    logic         line_done;
    logic         overflow;

    always #5 clk = ~clk;

    uart_line_assembler #(.MAX_CHARS(MAX_CHARS)) dut (
        .iCLK      (clk),
        .iRST_N    (rst_n),
        .iRX_VALID (rx_valid),
        .iRX_DATA  (rx_data),
        .oRX_READY (rx_ready),
        .iCLEAR    (clear),
        .oMESS     (mess),
        .oLENGTH   (length),
        .oLINE_DONE(line_done),
        .oOVERFLOW (overflow)
    );

    typedef struct {
        int           len;
        logic [W-1:0] text;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t        sb[$];
    byte unsigned line_q[$];
    bit          m_last_cr = 0;
    bit          m_ovf     = 0;
    int          checks    = 0;
    int          errors    = 0;
    int          pulses    = 0;
    int          cyc       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_mess(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] line_text();
        logic [W-1:0] m;
        m = SPACES;
        for (int i = 0; i < line_q.size(); i++) m[8*i +: 8] = line_q[i];
        return m;
    endfunction

    task automatic push_commit(int acc_cyc);
        exp_t e;
        e.len  = line_q.size();
        e.text = line_text();
        e.ovf  = m_ovf;
        e.cyc  = acc_cyc + 2;
        sb.push_back(e);
        line_q.delete();
    endtask

    // Reference model: applies the line rules to one accepted byte.
    task automatic model_accept(byte unsigned b, int acc_cyc);
        if (b == 8'h0D) begin
            m_last_cr = 1;
            push_commit(acc_cyc);
        end else begin
            if (b == 8'h0A) begin
                if (!(m_last_cr && line_q.size() == 0)) push_commit(acc_cyc);
            end else if (b >= 8'h20 && b <= 8'h7E) begin
                if (line_q.size() < MAX_CHARS) line_q.push_back(b);
                else m_ovf = 1;
            end
`ifdef UART_LINE_BACKSPACE_EN
            else if (b == 8'h08 || b == 8'h7F) begin
                if (line_q.size() > 0) void'(line_q.pop_back());
            end
`endif
            m_last_cr = 0;
        end
    endtask

    task automatic model_clear();
        line_q.delete();
        m_last_cr = 0;
        m_ovf     = 0;
    endtask

    // Entered and left at a negedge; rx_valid stays high after acceptance.
    task automatic send_byte(byte unsigned b, output int stalls);
        int acc;
        rx_valid = 1'b1;
        rx_data  = b;
        stalls   = 0;
        while (!rx_ready) begin
            if (stalls >= 20) begin
                checks++;
                errors++;
                $display("FAIL rx_ready_timeout: got 0 expected 1 within 20 cycles");
                rx_valid = 1'b0;
                return;
            end
            @(negedge clk);
            stalls++;
        end
        acc = cyc;
        @(posedge clk);
        model_accept(b, acc);
        @(negedge clk);
    endtask

    task automatic send_str(string s);
        int st;
        for (int i = 0; i < s.len(); i++) send_byte(s[i], st);
    endtask

    task automatic idle(int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops one expectation per oLINE_DONE pulse.
    logic prev_done = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            prev_done <= 1'b0;
        end else begin
            if (line_done) begin
                pulses++;
                if (prev_done) begin
                    checks++;
                    errors++;
                    $display("FAIL line_done_width: got 2+ cycles expected 1");
                end
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_line_done: got pulse at cycle %0d expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("commit_length", 32'(length), e.len);
                    chk_mess("commit_mess", mess, e.text);
                    chk("commit_overflow", 32'(overflow), 32'(e.ovf));
                    chk("commit_cycle", cyc, e.cyc);
                end
            end
            prev_done <= line_done;
        end
    end

    initial begin : stimulus
        int st;
        int p0;
        int r;
        byte unsigned b;

        // Reset state
        repeat (3) @(negedge clk);
        chk_mess("reset_mess", mess, SPACES);
        chk("reset_length", 32'(length), 0);
        chk("reset_line_done", 32'(line_done), 0);
        chk("reset_overflow", 32'(overflow), 0);
        chk("reset_rx_ready", 32'(rx_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Simple line
        send_str("HI");
        send_byte(8'h0D, st);
        idle(3);
        chk("hi_length", 32'(length), 2);
        chk("hi_low_chars", 32'(mess[15:0]), 32'h4948);

        // CRLF counts once, bare LF terminates
        p0 = pulses;
        send_str("AB");
        send_byte(8'h0D, st);
        send_byte(8'h0A, st);
        send_str("C");
        send_byte(8'h0A, st);
        idle(4);
        chk("crlf_pulses", pulses - p0, 2);
        chk("crlf_last_length", 32'(length), 1);

        // Full buffer and overflow
        for (int i = 0; i < MAX_CHARS + 1; i++) send_byte("Z", st);
        send_byte(8'h0D, st);
        idle(3);
        chk("full_length", 32'(length), MAX_CHARS);
        chk("full_overflow", 32'(overflow), 1);
        send_str("Q");
        send_byte(8'h0D, st);
        idle(3);
        chk("after_full_length", 32'(length), 1);
        chk("overflow_sticky", 32'(overflow), 1);

        // Clear while a CR is presented
        p0 = pulses;
        send_str("XY");
        rx_data = 8'h0D;
        clear   = 1'b1;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        clear = 1'b0;
        idle(3);
        chk("clear_length", 32'(length), 0);
        chk_mess("clear_mess", mess, SPACES);
        chk("clear_overflow", 32'(overflow), 0);
        chk("clear_no_pulse", pulses - p0, 0);
        send_byte(8'h0D, st);
        idle(3);
        chk("after_clear_length", 32'(length), 0);

        // Clear overriding a commit in progress
        p0 = pulses;
        send_str("AB");
        send_byte(8'h0D, st);
        clear    = 1'b1;
        rx_valid = 1'b0;
        void'(sb.pop_back());
        model_clear();
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        idle(3);
        chk("clear_commit_no_pulse", pulses - p0, 0);
        chk("clear_commit_length", 32'(length), 0);

        // Back-to-back bytes across a commit
        send_byte("A", st);
        chk("stall_before_cr", st, 0);
        send_byte(8'h0D, st);
        send_byte("B", st);
        chk("stall_after_terminator", st, 1);
        send_byte(8'h0D, st);
        idle(3);
        chk("held_valid_length", 32'(length), 1);
        chk("held_valid_char", 32'(mess[7:0]), 32'h42);

        // Backspace handling
        send_str("ABC");
        send_byte(8'h08, st);
        send_str("D");
        send_byte(8'h0D, st);
        idle(3);
`ifdef UART_LINE_BACKSPACE_EN
        chk("backspace_length", 32'(length), 3);
        chk("backspace_text", 32'(mess[23:0]), 32'h444241);
`else
        chk("backspace_length", 32'(length), 4);
        chk("backspace_text", 32'(mess[31:0]), 32'h44434241);
`endif
        send_byte(8'h7F, st);
        send_str("K");
        send_byte(8'h0D, st);
        idle(3);
        chk("backspace_empty_length", 32'(length), 1);

        // Randomized traffic
        for (int it = 0; it < 1500; it++) begin
            r = $urandom_range(0, 199);
            if (((it / 300) % 2) == 1 && r < 12) r = r + 30;
            if (r < 6) b = 8'h0D;
            else if (r < 10) b = 8'h0A;
            else if (r < 18) begin
                b = 8'($urandom_range(1, 31));
                if (b == 8'h0D || b == 8'h0A) b = 8'h01;
            end
            else if (r < 24) b = ($urandom_range(0, 1) != 0) ? 8'h08 : 8'h7F;
            else if (r < 28) b = 8'($urandom_range(128, 255));
            else b = 8'($urandom_range(32, 126));
            send_byte(b, st);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            if ($urandom_range(0, 149) == 0 && sb.size() == 0) begin
                rx_valid = 1'b1;
                rx_data  = 8'($urandom_range(0, 255));
                clear    = 1'b1;
                @(posedge clk);
                model_clear();
                @(negedge clk);
                clear = 1'b0;
                chk("random_clear_overflow", 32'(overflow), 0);
            end
        end
        send_byte(8'h0D, st);
        idle(3);

        // Asynchronous reset mid-line
        for (int i = 0; i < MAX_CHARS + 1; i++) send_byte("R", st);
        send_str("PQ");
        #2 rst_n = 1'b0;
        #1;
        chk_mess("async_reset_mess", mess, SPACES);
        chk("async_reset_length", 32'(length), 0);
        chk("async_reset_overflow", 32'(overflow), 0);
        chk("async_reset_rx_ready", 32'(rx_ready), 1);
        model_clear();
        sb.delete();
        rx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h0D, st);
        idle(3);
        chk("post_reset_length", 32'(length), 0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        chk("pending_lines", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
